rtc_display_scan: RTL



---
 rtl/rtc_display_scan_pkg.sv | 15 +
 rtl/rtc_display_scan_bcd_to_7seg.sv | 25 ++
 rtl/rtc_display_scan.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rtc_display_scan_pkg.sv
// Shared types and constants for the stopwatch 7-segment display scanner.
package rtc_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam int         NUM_DIGITS = 6;

endpackage

// File: rtl/rtc_display_scan_bcd_to_7seg.sv
// Combinational BCD to active-low {g,f,e,d,c,b,a} decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import rtc_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/rtc_display_scan.sv
// Six-digit common-anode display scanner with per-frame count snapshot and inter-digit gap.
// Define RTC_DISPLAY_BLANK_EN to blank leading zeros on digits 5..3.
module rtc_display_scan
  import rtc_display_pkg::*;
#(
  parameter int          DIGIT_CYCLES = 1000,
  parameter int          GAP_CYCLES   = 16,
  parameter logic [5:0]  DP_MASK      = 6'b010100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [23:0] i_count,
  input  logic        i_displayenb,
  output logic [5:0]  o_anode,
  output logic [6:0]  o_segment,
  output logic        o_dp,
  output logic        o_frame_done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int TMR_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [TMR_W-1:0] DRIVE_LOAD = TMR_W'(DIGIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic [23:0]       r_snap, w_snap_nxt;
  logic              w_digit_end;
  logic              w_fd_nxt;
  logic [3:0]        w_nib;
  logic [6:0]        w_dec;
  logic              w_blank;
  logic [5:0]        w_anode_nxt;
  logic [6:0]        w_seg_nxt;
  logic              w_dp_nxt;

  // Outputs are registered from the next-state view so they change on the same edge as the FSM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_tmr        <= '0;
      r_idx        <= 3'd0;
      r_snap       <= 24'h0;
      o_anode      <= 6'h3F;
      o_segment    <= SEG_OFF;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmr        <= w_tmr_nxt;
      r_idx        <= w_idx_nxt;
      r_snap       <= w_snap_nxt;
      o_anode      <= w_anode_nxt;
      o_segment    <= w_seg_nxt;
      o_dp         <= w_dp_nxt;
      o_frame_done <= w_fd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    w_tmr_nxt   = (r_tmr != '0) ? r_tmr - TMR_W'(1) : '0;
    w_fd_nxt    = 1'b0;
    w_digit_end = 1'b0;
    if (!i_displayenb) begin
      w_state_nxt = IDLE;
      w_tmr_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = LOAD;
          w_tmr_nxt   = '0;
        end
        LOAD: begin
          w_snap_nxt  = i_count;
          w_idx_nxt   = 3'd0;
          w_state_nxt = DRIVE;
          w_tmr_nxt   = DRIVE_LOAD;
        end
        DRIVE: begin
          if (r_tmr == '0) begin
            if (GAP_CYCLES > 0) begin
              w_state_nxt = GAP;
              w_tmr_nxt   = GAP_LOAD;
            end else begin
              w_digit_end = 1'b1;
            end
          end
        end
        GAP: begin
          if (r_tmr == '0) w_digit_end = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
      // Last digit wraps to LOAD so every frame starts from a fresh snapshot.
      if (w_digit_end) begin
        if (r_idx < LAST_IDX) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_state_nxt = DRIVE;
          w_tmr_nxt   = DRIVE_LOAD;
        end else begin
          w_fd_nxt    = 1'b1;
          w_state_nxt = LOAD;
          w_tmr_nxt   = '0;
        end
      end
    end
  end

  always_comb begin
    case (w_idx_nxt)
      3'd0:    w_nib = w_snap_nxt[3:0];
      3'd1:    w_nib = w_snap_nxt[7:4];
      3'd2:    w_nib = w_snap_nxt[11:8];
      3'd3:    w_nib = w_snap_nxt[15:12];
      3'd4:    w_nib = w_snap_nxt[19:16];
      3'd5:    w_nib = w_snap_nxt[23:20];
      default: w_nib = 4'h0;
    endcase
  end

  bcd_to_7seg u_dec (
    .i_bcd (w_nib),
    .o_seg (w_dec)
  );

`ifdef RTC_DISPLAY_BLANK_EN
  logic w_z5, w_z4, w_z3;
  assign w_z5    = (w_snap_nxt[23:20] == 4'h0);
  assign w_z4    = w_z5 && (w_snap_nxt[19:16] == 4'h0);
  assign w_z3    = w_z4 && (w_snap_nxt[15:12] == 4'h0);
  assign w_blank = ((w_idx_nxt == 3'd5) && w_z5) ||
                   ((w_idx_nxt == 3'd4) && w_z4) ||
                   ((w_idx_nxt == 3'd3) && w_z3);
`else
  assign w_blank = 1'b0;
`endif

  // A blanked digit keeps its anode asserted so scan timing is unaffected.
  always_comb begin
    w_anode_nxt = 6'h3F;
    w_seg_nxt   = SEG_OFF;
    w_dp_nxt    = 1'b1;
    if (w_state_nxt == DRIVE) begin
      w_anode_nxt = ~(6'd1 << w_idx_nxt);
      if (!w_blank) begin
        w_seg_nxt = w_dec;
        w_dp_nxt  = ~DP_MASK[w_idx_nxt];
      end
    end
  end

endmodule
